drink_dispense_sequencer: RTL and testbench

Sequences the drink-making hardware once the coin/selection FSM has decided to serve a drink. It accepts a serve request for tea or coffee over a valid/ready handshake and checks the water and coffee sensors. It then drives the heater, the powder dosers and the water valve through fixed timed phases, and reports either a one-cycle done or a coded fault. It sits between the vending FSM (upstream) and the actuator drivers (downstream).

---
 rtl/drink_pkg.sv | 23 ++
 rtl/dispense_timer.sv | 41 ++++
 rtl/drink_dispense_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_drink_dispense_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drink_pkg.sv
// Shared encodings for the drink dispense sequencer: FSM states, drink codes
// and fault codes reported to the vending FSM.
package drink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_HEAT  = 3'd2,
    ST_DOSE  = 3'd3,
    ST_POUR  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_e;

  localparam logic DRINK_TEA    = 1'b0;
  localparam logic DRINK_COFFEE = 1'b1;

  localparam logic [1:0] FLT_NONE   = 2'b00;
  localparam logic [1:0] FLT_WATER  = 2'b01;
  localparam logic [1:0] FLT_COFFEE = 2'b10;
  localparam logic [1:0] FLT_HEAT   = 2'b11;

endpackage

// File: rtl/dispense_timer.sv
// Phase timer: saturating up-counter with synchronous clear and enable.
// tc_o flags that the count has reached the limit supplied for the current
// phase; the counter never advances past the limit, so it cannot wrap.
module dispense_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == limit_i);

  // Next count: clear wins, otherwise advance until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/drink_dispense_sequencer.sv
// Drink dispense sequencer: accepts a tea/coffee serve request, checks the
// stock sensors, then runs heat, dose and pour phases and reports done or a
// coded fault. All actuator and status outputs are decoded from the state
// register alone, so the asynchronous reset closes every actuator at once.
module drink_dispense_sequencer
  import drink_pkg::*;
#(
  parameter int HEAT_TIMEOUT = 32,
  parameter int DOSE_CYCLES  = 4,
  parameter int POUR_CYCLES  = 12,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_drink,
  output logic       req_ready,
  input  logic       water_ok,
  input  logic       coffee_ok,
  input  logic       temp_ok,
  output logic       heater_on,
  output logic       doser_tea,
  output logic       doser_coffee,
  output logic       valve_water,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [CNT_W-1:0] HEAT_LIM = CNT_W'(HEAT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DOSE_LIM = CNT_W'(DOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POUR_LIM = CNT_W'(POUR_CYCLES - 1);

  state_e           state_q, state_d;
  logic             drink_q, drink_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic [CNT_W-1:0] tmr_limit_s;
  logic             tmr_tc_s;

  dispense_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr_s),
    .en_i    (tmr_en_s),
    .limit_i (tmr_limit_s),
    .tc_o    (tmr_tc_s)
  );

  // State, latched drink and fault code registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      drink_q      <= DRINK_TEA;
      fault_code_q <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      drink_q      <= drink_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state logic; the timer is cleared on every phase entry.
  always_comb begin
    state_d      = state_q;
    drink_d      = drink_q;
    fault_code_d = fault_code_q;
    tmr_clr_s    = 1'b0;
    tmr_en_s     = 1'b0;
    tmr_limit_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d      = ST_CHECK;
          drink_d      = req_drink;
          fault_code_d = FLT_NONE;
          tmr_clr_s    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        tmr_clr_s = 1'b1;
        if (!water_ok) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_WATER;
        end else if ((drink_q == DRINK_COFFEE) && !coffee_ok) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_COFFEE;
        end else begin
          state_d = ST_HEAT;
        end
      end
      ST_HEAT: begin
        tmr_limit_s = HEAT_LIM;
        if (temp_ok) begin
          state_d   = ST_DOSE;
          tmr_clr_s = 1'b1;
        end else if (tmr_tc_s) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_HEAT;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_DOSE: begin
        tmr_limit_s = DOSE_LIM;
        if (tmr_tc_s) begin
          state_d   = ST_POUR;
          tmr_clr_s = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_POUR: begin
        tmr_limit_s = POUR_LIM;
        if (!water_ok) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_WATER;
        end else if (tmr_tc_s) begin
          state_d = ST_DONE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from the state register only.
  always_comb begin
    req_ready    = 1'b0;
    heater_on    = 1'b0;
    doser_tea    = 1'b0;
    doser_coffee = 1'b0;
    valve_water  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    fault        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      ST_CHECK: begin
        busy = 1'b1;
      end
      ST_HEAT: begin
        busy      = 1'b1;
        heater_on = 1'b1;
      end
      ST_DOSE: begin
        busy         = 1'b1;
        heater_on    = 1'b1;
        doser_tea    = (drink_q == DRINK_TEA);
        doser_coffee = (drink_q == DRINK_COFFEE);
      end
      ST_POUR: begin
        busy        = 1'b1;
        heater_on   = 1'b1;
        valve_water = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ST_FAULT: begin
        busy  = 1'b1;
        fault = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_drink_dispense_sequencer.sv
// Self-checking bench for drink_dispense_sequencer. Each scenario pushes the
// expected transaction outcome (from a small behavioural model) into a
// scoreboard queue, drives the request, then pops and compares when the DUT
// reports done or fault.
module tb_drink_dispense_sequencer;

  localparam int HEAT_TIMEOUT = 32;
  localparam int DOSE_CYCLES  = 4;
  localparam int POUR_CYCLES  = 12;
  localparam int NEVER        = 100000;
  localparam int NONE         = -1;

  typedef struct packed {
    logic       is_fault;
    int         latency;
    int         heat;
    int         tea;
    int         cof;
    int         valve;
    logic [1:0] code;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_drink, req_ready;
  logic       water_ok, coffee_ok, temp_ok;
  logic       heater_on, doser_tea, doser_coffee, valve_water;
  logic       busy, done, fault;
  logic [1:0] fault_code;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t exp_q[$];

  drink_dispense_sequencer #(
    .HEAT_TIMEOUT(HEAT_TIMEOUT), .DOSE_CYCLES(DOSE_CYCLES),
    .POUR_CYCLES(POUR_CYCLES), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_drink(req_drink),
    .req_ready(req_ready), .water_ok(water_ok), .coffee_ok(coffee_ok),
    .temp_ok(temp_ok), .heater_on(heater_on), .doser_tea(doser_tea),
    .doser_coffee(doser_coffee), .valve_water(valve_water), .busy(busy),
    .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Expected outcome. Cycle 0 is the accept cycle; temp_ok is 1 from cycle
  // temp_hi on; water_ok is 0 only in cycle drop.
  function automatic rec_t model(input logic drink, input logic cok,
                                 input int temp_hi, input int drop);
    rec_t e;
    int   h;
    int   ps;
    e = '0;
    if (drop == 1) begin
      e.is_fault = 1'b1; e.latency = 2; e.code = 2'b01;
      return e;
    end
    if (drink && !cok) begin
      e.is_fault = 1'b1; e.latency = 2; e.code = 2'b10;
      return e;
    end
    if (temp_hi > 1 + HEAT_TIMEOUT) begin
      e.is_fault = 1'b1; e.heat = HEAT_TIMEOUT;
      e.latency = 2 + HEAT_TIMEOUT; e.code = 2'b11;
      return e;
    end
    h  = (temp_hi <= 2) ? 1 : temp_hi - 1;
    ps = 2 + h + DOSE_CYCLES;
    if (drink) e.cof = DOSE_CYCLES;
    else       e.tea = DOSE_CYCLES;
    if (drop >= ps && drop < ps + POUR_CYCLES) begin
      e.valve = drop - ps + 1; e.is_fault = 1'b1;
      e.latency = drop + 1; e.code = 2'b01;
    end else begin
      e.valve = POUR_CYCLES; e.latency = ps + POUR_CYCLES;
    end
    e.heat = h + DOSE_CYCLES + e.valve;
    return e;
  endfunction

  // Drive one request and record what the DUT does until done/fault.
  task automatic run_txn(input logic drink, input logic cok, input int temp_hi,
                         input int drop, input bit hold, output rec_t o,
                         output bit tmo, output bit both, output bit rviol,
                         output logic [1:0] code_chk);
    o = '0; tmo = 1'b1; both = 1'b0; rviol = 1'b0; code_chk = 2'b00;
    @(negedge clk);
    req_valid = 1'b1; req_drink = drink; coffee_ok = cok;
    water_ok = (drop != 0); temp_ok = (temp_hi <= 0);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) code_chk = fault_code;
      if (heater_on)    o.heat  = o.heat + 1;
      if (doser_tea)    o.tea   = o.tea + 1;
      if (doser_coffee) o.cof   = o.cof + 1;
      if (valve_water)  o.valve = o.valve + 1;
      if (doser_tea && doser_coffee) both = 1'b1;
      if (busy && req_ready) rviol = 1'b1;
      if (done || fault) begin
        o.is_fault = fault; o.latency = c; o.code = fault_code; tmo = 1'b0;
        break;
      end
      if (!hold) req_valid = 1'b0;
      temp_ok  = (c >= temp_hi);
      water_ok = (c != drop);
    end
    if (!hold) req_valid = 1'b0;
    water_ok = 1'b1; temp_ok = 1'b1; coffee_ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_drink = 1'b0;
    water_ok = 1'b1; coffee_ok = 1'b1; temp_ok = 1'b1;
    #12;
    n_cmp++;
    if ({heater_on, doser_tea, doser_coffee, valve_water, busy, done, fault} !== 7'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b required 0000000",
        {heater_on, doser_tea, doser_coffee, valve_water, busy, done, fault});
    end
    n_cmp++;
    if (fault_code !== 2'b00) begin
      n_bad++; $display("FAIL reset_code: got %b required 00", fault_code);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_tea_baseline();
    rec_t o, e; bit tmo, both, rv; logic [1:0] cc;
    exp_q.push_back(model(1'b0, 1'b1, 0, NONE));
    run_txn(1'b0, 1'b1, 0, NONE, 1'b0, o, tmo, both, rv, cc);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmo || o !== e) begin
      n_bad++; $display("FAIL tea_baseline: got %p tmo=%0d required %p", o, tmo, e);
    end
    n_cmp++;
    if (both !== 1'b0) begin
      n_bad++; $display("FAIL tea_both_dosers: got %0d required 0", both);
    end
  endtask

  task automatic test_coffee_no_stock();
    rec_t o, e; bit tmo, both, rv; logic [1:0] cc;
    exp_q.push_back(model(1'b1, 1'b0, 0, NONE));
    run_txn(1'b1, 1'b0, 0, NONE, 1'b0, o, tmo, both, rv, cc);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmo || o !== e) begin
      n_bad++; $display("FAIL coffee_no_stock: got %p tmo=%0d required %p", o, tmo, e);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fault_code !== 2'b10) begin
      n_bad++; $display("FAIL coffee_code_held: got %b required 10", fault_code);
    end
    exp_q.push_back(model(1'b0, 1'b1, 0, NONE));
    run_txn(1'b0, 1'b1, 0, NONE, 1'b0, o, tmo, both, rv, cc);
    e = exp_q.pop_front();
    n_cmp++;
    if (cc !== 2'b00) begin
      n_bad++; $display("FAIL code_clear_at_accept: got %b required 00", cc);
    end
    n_cmp++;
    if (tmo || o !== e) begin
      n_bad++; $display("FAIL tea_after_fault: got %p tmo=%0d required %p", o, tmo, e);
    end
  endtask

  task automatic test_heat_delay();
    rec_t o, e; bit tmo, both, rv; logic [1:0] cc;
    exp_q.push_back(model(1'b1, 1'b1, 6, NONE));
    run_txn(1'b1, 1'b1, 6, NONE, 1'b0, o, tmo, both, rv, cc);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmo || o !== e) begin
      n_bad++; $display("FAIL coffee_heat_delay: got %p tmo=%0d required %p", o, tmo, e);
    end
    n_cmp++;
    if (both !== 1'b0) begin
      n_bad++; $display("FAIL coffee_both_dosers: got %0d required 0", both);
    end
  endtask

  task automatic test_heat_timeout();
    rec_t o, e; bit tmo, both, rv; logic [1:0] cc;
    exp_q.push_back(model(1'b0, 1'b1, NEVER, NONE));
    run_txn(1'b0, 1'b1, NEVER, NONE, 1'b0, o, tmo, both, rv, cc);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmo || o !== e) begin
      n_bad++; $display("FAIL heat_timeout: got %p tmo=%0d required %p", o, tmo, e);
    end
    @(negedge clk);
    n_cmp++;
    if (heater_on !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL heat_timeout_after: heater=%b ready=%b required 0 1",
        heater_on, req_ready);
    end
  endtask

  task automatic test_no_water_check();
    rec_t o, e; bit tmo, both, rv; logic [1:0] cc;
    exp_q.push_back(model(1'b1, 1'b1, 0, 1));
    run_txn(1'b1, 1'b1, 0, 1, 1'b0, o, tmo, both, rv, cc);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmo || o !== e) begin
      n_bad++; $display("FAIL no_water_check: got %p tmo=%0d required %p", o, tmo, e);
    end
  endtask

  task automatic test_back_to_back();
    rec_t o, e; bit tmo, both, rv; logic [1:0] cc; bit seen;
    exp_q.push_back(model(1'b0, 1'b1, 0, 12));
    run_txn(1'b0, 1'b1, 0, 12, 1'b1, o, tmo, both, rv, cc);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmo || o !== e) begin
      n_bad++; $display("FAIL pour_water_drop: got %p tmo=%0d required %p", o, tmo, e);
    end
    n_cmp++;
    if (rv !== 1'b0) begin
      n_bad++; $display("FAIL ready_while_busy: got %0d required 0", rv);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || valve_water !== 1'b0) begin
      n_bad++; $display("FAIL return_idle: ready=%b busy=%b valve=%b required 1 0 0",
        req_ready, busy, valve_water);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL held_req_accept: busy=%b ready=%b required 1 0", busy, req_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL held_req_done: got no done within 40 cycles required done");
    end
  endtask

  task automatic test_reset_mid_pour();
    @(negedge clk);
    req_valid = 1'b1; req_drink = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if (valve_water !== 1'b1) begin
      n_bad++; $display("FAIL pour_precondition: valve=%b required 1", valve_water);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({valve_water, heater_on, busy} !== 3'b000) begin
      n_bad++; $display("FAIL async_reset: valve/heater/busy=%b required 000",
        {valve_water, heater_on, busy});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || fault_code !== 2'b00) begin
      n_bad++; $display("FAIL after_reset_idle: ready=%b busy=%b code=%b required 1 0 00",
        req_ready, busy, fault_code);
    end
  endtask

  initial begin
    test_reset();
    test_tea_baseline();
    test_coffee_no_stock();
    test_heat_delay();
    test_heat_timeout();
    test_no_water_check();
    test_back_to_back();
    test_reset_mid_pour();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
